// File: rtl/blt_pool_ctl_pkg.sv
// Shared game constants: screen geometry, coordinate width, vertical
// play-field bounds, and the fire-control state encoding.
package blt_pool_ctl_pkg;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;
    localparam int COORD_W  = 9;
    localparam int Y_MIN    = 0;
    localparam int Y_MAX    = SCREEN_H - 1;

    typedef enum logic [0:0] {
        FIRE_IDLE = 1'b0,
        FIRE_COOL = 1'b1
    } fire_state_e;

    // Counter width for a value range 0..v-1, never narrower than one bit.
    function automatic int cnt_width(input int v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

endpackage

// File: rtl/blt_pool_ctl_free_slot_enc.sv
// Lowest-index free-slot priority encoder: one-hot select of the lowest
// set bit of free_i, plus a flag when no bit is set.
module free_slot_enc #(
    parameter int N = 13
) (
    input  logic [N-1:0] free_i,
    output logic [N-1:0] onehot_o,
    output logic         none_free_o
);

    // Two's-complement trick isolates the lowest set bit.
    assign onehot_o    = free_i & (~free_i + N'(1));
    assign none_free_o = ~|free_i;

endmodule

// File: rtl/blt_pool_ctl.sv
// Bullet pool controller: spawns bullets on accepted fire requests into the
// lowest free slot, moves live bullets vertically on a divided tick, retires
// them at the play-field edge and drops them on collision strobes.
module blt_pool_ctl
    import blt_pool_ctl_pkg::*;
#(
    parameter int NUM_BLT  = 13,
    parameter int COORD_W  = blt_pool_ctl_pkg::COORD_W,
    parameter int MOVE_DIV = 50,
    parameter int STEP     = 2,
    parameter int DIR      = 0,
    parameter int Y_MIN    = blt_pool_ctl_pkg::Y_MIN,
    parameter int Y_MAX    = blt_pool_ctl_pkg::Y_MAX,
    parameter int COOLDOWN = 1000
) (
    input  logic                         clk_main,
    input  logic                         rst,
    input  logic                         en,
    input  logic                         fire_req,
    input  logic [COORD_W-1:0]           fire_x,
    input  logic [COORD_W-1:0]           fire_y,
    input  logic [NUM_BLT-1:0]           eli_blt,
    output logic [NUM_BLT*COORD_W-1:0]   blt_x,
    output logic [NUM_BLT*COORD_W-1:0]   blt_y,
    output logic [NUM_BLT-1:0]           blt_vi,
    output logic                         fire_ack,
    output logic                         pool_full,
    output logic [$clog2(NUM_BLT+1)-1:0] active_cnt
);

    localparam int TICK_W = cnt_width(MOVE_DIV);
    localparam int COOL_W = cnt_width(COOLDOWN);
    localparam int CNT_W  = $clog2(NUM_BLT + 1);

    // Movement arithmetic is one bit wider so it can neither wrap nor alias.
    localparam logic [COORD_W:0] STEP_E  = (COORD_W + 1)'(STEP);
    localparam logic [COORD_W:0] LO_E    = (COORD_W + 1)'(Y_MIN + STEP);
    localparam logic [COORD_W:0] Y_MAX_E = (COORD_W + 1)'(Y_MAX);

    logic [TICK_W-1:0]  tick_q;
    logic [COOL_W-1:0]  cool_q;
    fire_state_e        state_q;

    logic [NUM_BLT-1:0] vi_q, vi_d;
    logic [COORD_W-1:0] x_q [NUM_BLT];
    logic [COORD_W-1:0] x_d [NUM_BLT];
    logic [COORD_W-1:0] y_q [NUM_BLT];
    logic [COORD_W-1:0] y_d [NUM_BLT];

    logic [COORD_W:0]   y_ext  [NUM_BLT];
    logic [COORD_W:0]   y_mv   [NUM_BLT];
    logic [NUM_BLT-1:0] retire;

    logic [NUM_BLT-1:0] free_onehot;
    logic               none_free;
    logic               tick;
    logic               accept;

    free_slot_enc #(
        .N (NUM_BLT)
    ) u_free_slot_enc (
        .free_i      (~vi_q),
        .onehot_o    (free_onehot),
        .none_free_o (none_free)
    );

    assign tick      = en && (tick_q == TICK_W'(MOVE_DIV - 1));
    assign pool_full = none_free;
    // Ack is gated by reset so nothing is reported while the pool is held clear.
    assign accept    = rst && en && fire_req && !none_free && (state_q == FIRE_IDLE);
    assign fire_ack  = accept;
    assign blt_vi    = vi_q;

    generate
        for (genvar gi = 0; gi < NUM_BLT; gi++) begin : g_slot
            assign y_ext[gi]  = {1'b0, y_q[gi]};
            assign y_mv[gi]   = (DIR != 0) ? (y_ext[gi] + STEP_E) : (y_ext[gi] - STEP_E);
            assign retire[gi] = (DIR != 0) ? (y_mv[gi] > Y_MAX_E) : (y_ext[gi] < LO_E);
            assign blt_x[gi*COORD_W +: COORD_W] = x_q[gi];
            assign blt_y[gi*COORD_W +: COORD_W] = y_q[gi];
        end
    endgenerate

    // Population count of the live-slot bits.
    always_comb begin
        active_cnt = '0;
        for (int k = 0; k < NUM_BLT; k++) begin
            active_cnt = active_cnt + CNT_W'(vi_q[k]);
        end
    end

    // Per-slot next state: elimination first, then spawn, then move/retire.
    always_comb begin
        vi_d = vi_q;
        for (int k = 0; k < NUM_BLT; k++) begin
            x_d[k] = x_q[k];
            y_d[k] = y_q[k];
            if (eli_blt[k] && vi_q[k]) begin
                vi_d[k] = 1'b0;
            end else if (en) begin
                if (accept && free_onehot[k]) begin
                    vi_d[k] = 1'b1;
                    x_d[k]  = fire_x;
                    y_d[k]  = fire_y;
                end else if (vi_q[k] && tick) begin
                    if (retire[k]) begin
                        vi_d[k] = 1'b0;
                    end else begin
                        y_d[k] = y_mv[k][COORD_W-1:0];
                    end
                end
            end
        end
    end

    // Slot registers.
    always_ff @(posedge clk_main or negedge rst) begin
        if (!rst) begin
            vi_q <= '0;
            for (int k = 0; k < NUM_BLT; k++) begin
                x_q[k] <= '0;
                y_q[k] <= '0;
            end
        end else begin
            vi_q <= vi_d;
            for (int k = 0; k < NUM_BLT; k++) begin
                x_q[k] <= x_d[k];
                y_q[k] <= y_d[k];
            end
        end
    end

    // Movement tick divider; holds its phase while disabled.
    always_ff @(posedge clk_main or negedge rst) begin
        if (!rst) begin
            tick_q <= '0;
        end else if (en) begin
            tick_q <= tick ? '0 : tick_q + TICK_W'(1);
        end
    end

    // Fire FSM: an accept opens a COOLDOWN-cycle window in which requests are dropped.
    always_ff @(posedge clk_main or negedge rst) begin
        if (!rst) begin
            state_q <= FIRE_IDLE;
            cool_q  <= '0;
        end else if (en) begin
            case (state_q)
                FIRE_IDLE: begin
                    if (accept && (COOLDOWN > 0)) begin
                        state_q <= FIRE_COOL;
                        cool_q  <= '0;
                    end
                end
                FIRE_COOL: begin
                    if (cool_q == COOL_W'(COOLDOWN - 1)) begin
                        state_q <= FIRE_IDLE;
                        cool_q  <= '0;
                    end else begin
                        cool_q <= cool_q + COOL_W'(1);
                    end
                end
                default: begin
                    state_q <= FIRE_IDLE;
                    cool_q  <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_blt_pool_ctl.sv
// Directed bench for blt_pool_ctl: one default-parameter instance and one
// fast instance (COOLDOWN=0, MOVE_DIV=4) sharing clock, reset, enable and
// spawn position.
module tb_blt_pool_ctl;

    localparam int N  = 13;
    localparam int CW = 9;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic [CW-1:0] fire_x, fire_y;
    logic          fire_req_a, fire_req_b;
    logic [N-1:0]  eli_a, eli_b;

    logic [N*CW-1:0] blt_x_a, blt_y_a, blt_x_b, blt_y_b;
    logic [N-1:0]    vi_a, vi_b;
    logic            ack_a, ack_b, full_a, full_b;
    logic [3:0]      cnt_a, cnt_b;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    blt_pool_ctl u_def (
        .clk_main (clk),   .rst (rst),       .en (en),
        .fire_req (fire_req_a), .fire_x (fire_x), .fire_y (fire_y),
        .eli_blt  (eli_a),
        .blt_x    (blt_x_a), .blt_y (blt_y_a), .blt_vi (vi_a),
        .fire_ack (ack_a), .pool_full (full_a), .active_cnt (cnt_a)
    );

    blt_pool_ctl #(.COOLDOWN(0), .MOVE_DIV(4)) u_fast (
        .clk_main (clk),   .rst (rst),       .en (en),
        .fire_req (fire_req_b), .fire_x (fire_x), .fire_y (fire_y),
        .eli_blt  (eli_b),
        .blt_x    (blt_x_b), .blt_y (blt_y_b), .blt_vi (vi_b),
        .fire_ack (ack_b), .pool_full (full_b), .active_cnt (cnt_b)
    );

    function automatic int xa(input int k); return int'(blt_x_a[k*CW +: CW]); endfunction
    function automatic int ya(input int k); return int'(blt_y_a[k*CW +: CW]); endfunction
    function automatic int yb(input int k); return int'(blt_y_b[k*CW +: CW]); endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
        $display("check %-14s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    // Advance n rising edges, then settle 2 time units past the edge.
    task automatic adv(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    initial begin
        rst = 1'b1; en = 1'b1;
        fire_x = '0; fire_y = '0;
        fire_req_a = 1'b0; fire_req_b = 1'b0;
        eli_a = '0; eli_b = '0;

        // Reset state
        #2 rst = 1'b0;
        #1;
        chk("rst_vi_a", vi_a, 0);
        chk("rst_vi_b", vi_b, 0);
        chk("rst_cnt_a", cnt_a, 0);
        chk("rst_full_a", full_a, 0);
        chk("rst_ack_a", ack_a, 0);
        chk("rst_y_a", blt_y_a[31:0], 0);

        // Held fire at default parameters: acks at cycles 0, 1001, 2002
        @(posedge clk); #1 rst = 1'b1;
        fire_x = 9'd100; fire_y = 9'd400; fire_req_a = 1'b1;
        #1;
        chk("ack_c0", ack_a, 1);
        adv(1);
        chk("vi_c1", vi_a, 13'h0001);
        chk("x0_c1", xa(0), 100);
        chk("y0_c1", ya(0), 400);
        chk("ack_c1", ack_a, 0);
        adv(999);
        chk("ack_c1000", ack_a, 0);
        adv(1);
        chk("ack_c1001", ack_a, 1);
        adv(1);
        chk("vi_c1002", vi_a, 13'h0003);
        chk("y1_c1002", ya(1), 400);
        chk("y0_c1002", ya(0), 360);
        adv(1000);
        chk("ack_c2002", ack_a, 1);
        adv(1);
        chk("vi_c2003", vi_a, 13'h0007);
        chk("cnt_c2003", cnt_a, 3);
        chk("y2_c2003", ya(2), 400);
        chk("y0_c2003", ya(0), 320);

        // Freeze for 300 cycles; tick phase must resume where it stopped
        fire_req_a = 1'b0; en = 1'b0; fire_req_b = 1'b1;
        #1;
        chk("ack_b_frozen", ack_b, 0);
        adv(300);
        chk("y0_frozen", ya(0), 320);
        chk("y1_frozen", ya(1), 360);
        chk("vi_b_frozen", vi_b, 0);
        fire_req_b = 1'b0; en = 1'b1;
        adv(46);
        chk("y0_resume46", ya(0), 320);
        adv(1);
        chk("y0_resume47", ya(0), 318);

        // Five bullets into the fast pool, then asynchronous reset between edges
        fire_x = 9'd20; fire_y = 9'd100; fire_req_b = 1'b1;
        adv(5);
        fire_req_b = 1'b0;
        chk("cnt_b_5", cnt_b, 5);
        chk("cnt_a_3", cnt_a, 3);
        #2 rst = 1'b0;
        #1;
        chk("async_vi_a", vi_a, 0);
        chk("async_vi_b", vi_b, 0);
        chk("async_y0_a", ya(0), 0);
        fire_x = 9'd50; fire_y = 9'd10; fire_req_a = 1'b1;
        #1;
        chk("ack_in_rst", ack_a, 0);
        adv(2);
        @(posedge clk); #1 rst = 1'b1;
        #1;
        chk("ack_post_rst", ack_a, 1);
        adv(1);
        fire_req_a = 1'b0;
        chk("vi_post_rst", vi_a, 13'h0001);
        chk("x0_post_rst", xa(0), 50);
        chk("y0_post_rst", ya(0), 10);

        // Retire at the top edge: y=10 reaches 0 after 5 ticks, retires on the 6th
        adv(199);
        chk("y0_c200", ya(0), 2);
        adv(50);
        chk("y0_c250", ya(0), 0);
        chk("vi_c250", vi_a[0], 1);
        adv(49);
        chk("vi_c299", vi_a[0], 1);
        adv(1);
        chk("vi_retired", vi_a[0], 0);
        chk("y0_retired", ya(0), 0);

        // Fill the fast pool from cycle 300 (ticks at cycles 303, 307, 311, 315)
        fire_x = 9'd7; fire_y = 9'd300; fire_req_b = 1'b1;
        #1;
        chk("ack_b_c300", ack_b, 1);
        adv(13);
        chk("full_b", full_b, 1);
        chk("cnt_b_13", cnt_b, 13);
        chk("ack_b_full", ack_b, 0);
        chk("y0_b_fill", yb(0), 294);
        chk("y3_b_tickspawn", yb(3), 296);
        chk("y11_b_fill", yb(11), 300);
        eli_b = 13'h0010;
        adv(1);
        eli_b = '0; fire_y = 9'd200;
        #1;
        chk("vi4_b_eli", vi_b[4], 0);
        chk("ack_b_refill", ack_b, 1);
        adv(1);
        fire_req_b = 1'b0; eli_b = 13'h0008;
        #1;
        chk("vi4_b_refill", vi_b[4], 1);
        chk("y4_b_refill", yb(4), 200);
        chk("full_b_refill", full_b, 1);

        // Elimination coinciding with a tick
        adv(1);
        eli_b = '0;
        chk("vi3_b_eli_tick", vi_b[3], 0);
        chk("y3_b_eli_tick", yb(3), 296);
        chk("y0_b_tick", yb(0), 292);
        chk("y4_b_tick", yb(4), 198);
        chk("y12_b_tick", yb(12), 298);
        chk("cnt_b_12", cnt_b, 12);

        // Elimination still honoured while disabled; no spawn, no ack
        en = 1'b0; eli_b = 13'h0001; fire_req_b = 1'b1;
        #1;
        chk("ack_b_en0", ack_b, 0);
        adv(1);
        eli_b = '0; fire_req_b = 1'b0; en = 1'b1;
        chk("vi_b_en0", vi_b, 13'h1FF6);
        chk("y12_b_en0", yb(12), 298);
        chk("cnt_b_11", cnt_b, 11);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/blt_pool_ctl.md
BLT_POOL_CTL -- requirements
Module: blt_pool_ctl

Interface
REQ-001 Parameter NUM_BLT, default 13: number of bullet slots, range 1..32.
REQ-002 Parameter COORD_W, default 9: width of one coordinate in bits.
REQ-003 Parameter MOVE_DIV, default 50: clk_main cycles per movement tick, minimum 1.
REQ-004 Parameter STEP, default 2: pixels moved per tick, range 1..(2^COORD_W-1).
REQ-005 Parameter DIR, default 0: movement direction; 0 means up (y decreasing), 1 means down (y increasing).
REQ-006 Parameter Y_MIN, default 0, and Y_MAX, default 479: inclusive vertical play-field bounds.
REQ-007 Parameter COOLDOWN, default 1000: clk_main cycles between accepted shots.
REQ-008 clk_main  in  1  single clock; all logic on its rising edge.
REQ-009 rst  in  1  asynchronous, active-low reset.
REQ-010 en  in  1  block enable; 0 freezes all state.
REQ-011 fire_req  in  1  level request to spawn a bullet.
REQ-012 fire_x, fire_y  in  COORD_W each  spawn position, sampled in the accept cycle.
REQ-013 eli_blt  in  NUM_BLT  per-slot elimination strobe from the collision logic.
REQ-014 blt_x, blt_y  out  NUM_BLT*COORD_W each  packed slot coordinates; slot k occupies bits [k*COORD_W +: COORD_W].
REQ-015 blt_vi  out  NUM_BLT  slot-valid bits.
REQ-016 fire_ack  out  1  one-cycle pulse marking an accepted spawn.
REQ-017 pool_full  out  1  high when all blt_vi bits are 1.
REQ-018 active_cnt  out  $clog2(NUM_BLT+1)  population count of blt_vi.

Function
REQ-019 The fire FSM SHALL have two states: IDLE and COOL.
- IDLE to COOL when en=1, fire_req=1 and pool_full=0.
- COOL to IDLE after COOLDOWN cycles.
REQ-020 On accept, fire_ack SHALL pulse in the same cycle, and the lowest-index free slot SHALL load fire_x/fire_y with vi=1 at the next edge.
REQ-021 A request while pool_full=1 or in COOL SHALL be ignored: no ack, no state change, no queuing.
REQ-022 A continuously held fire_req SHALL produce one ack every COOLDOWN+1 cycles while slots are free.
REQ-023 The tick counter SHALL count 0..MOVE_DIV-1 while en=1 and assert tick at MOVE_DIV-1.
REQ-024 On tick, each valid slot SHALL move by STEP in direction DIR, with arithmetic done in COORD_W+1 bits and no wrap.
REQ-025 A slot SHALL retire (vi to 0) instead of moving when y<Y_MIN+STEP (DIR=0) or y+STEP>Y_MAX (DIR=1).
REQ-026 eli_blt[k]=1 SHALL clear vi[k] at the next edge, with priority over move and retire; eli on an invalid slot SHALL be ignored.
REQ-027 A slot freed in cycle t SHALL NOT count as free for spawning until cycle t+1.
REQ-028 A bullet spawned in a tick cycle SHALL NOT move in that tick.
REQ-029 The coordinates of an invalid slot SHALL hold their last value and carry no meaning.
REQ-030 With en=0, the tick counter, cooldown counter, FSM and slots SHALL freeze, fire_ack SHALL be 0, and eli_blt SHALL still be honoured.
REQ-031 pool_full and active_cnt SHALL be combinational functions of registered blt_vi.

Reset
REQ-032 rst=0 SHALL asynchronously clear blt_x, blt_y, blt_vi, fire_ack, the tick counter and the cooldown counter to 0, and set the FSM to IDLE.
REQ-033 Reset asserted mid-flight SHALL discard every bullet, and the first ack after release SHALL go to slot 0.

Structure
REQ-034 COORD_W, Y_MIN, Y_MAX and the screen constants (640x480) SHALL reside in a shared package used by all game blocks.
REQ-035 The lowest-free-slot search SHALL be the sub-module free_slot_enc (NUM_BLT-bit one-hot/index priority encoder with a none_free flag).

Verification
REQ-036 Defaults; fire_req held 1, fire_x=100, fire_y=400 -> acks at cycles 0, 1001, 2002; slots 0, 1, 2 valid at (100,400) at spawn.
REQ-037 Slot at y=10, DIR=0, STEP=2 -> after 5 ticks (250 cycles) y=0; the next tick retires it with vi=0 and y held at 0.
REQ-038 Fill all 13 slots (COOLDOWN=0) -> pool_full=1, active_cnt=13; fire_req ignored; eli_blt[4] then the next ack fills slot 4.
REQ-039 eli_blt[3] and tick in the same cycle -> slot 3 invalid, its y unchanged; other slots move by 2.
REQ-040 en=0 for 300 cycles with 2 live bullets -> y unchanged, no ack; en=1 resumes the tick phase where it stopped.
REQ-041 rst=0 asserted asynchronously between edges with 5 live bullets -> blt_vi=0 immediately; after release, the first ack spawns into slot 0.
